// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic {ARB_RUN, ARB_CLEAR} arb_state_t;

  typedef logic req_id_t;

  localparam req_id_t CLIENT0 = 1'b0;
  localparam req_id_t CLIENT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with registered last-grant; client 0 wins the first tie.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] req,
  input  logic       enable,
  input  logic       handshake,
  output logic [1:0] grant
);

  req_id_t last_grant;

  always_comb begin
    grant = '0;
    if (enable) begin
      if (&req) begin
        grant = (last_grant == CLIENT1) ? 2'b01 : 2'b10;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant <= CLIENT1;
    end else if (handshake) begin
      last_grant <= grant[1] ? CLIENT1 : CLIENT0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port memory, with a zero-sweep mode.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGHT = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0_Valid,
  input  logic              Req0_RW,
  input  logic [WIDTH-1:0]  Req0_Addr,
  input  logic [LENGHT-1:0] Req0_Din,
  output logic              Req0_Ready,
  input  logic              Req1_Valid,
  input  logic              Req1_RW,
  input  logic [WIDTH-1:0]  Req1_Addr,
  input  logic [LENGHT-1:0] Req1_Din,
  output logic              Req1_Ready,
  output logic              Rsp0_Valid,
  output logic [LENGHT-1:0] Rsp0_Data,
  output logic              Rsp1_Valid,
  output logic [LENGHT-1:0] Rsp1_Data,
  input  logic              Clear_Req,
  output logic              Busy,
  output logic              Clear_Done,
  output logic [LENGHT-1:0] Mem_Din,
  output logic [WIDTH-1:0]  Mem_Addr,
  output logic              Mem_RW,
  output logic              Mem_Valid,
  input  logic [LENGHT-1:0] Mem_Dout
);

  arb_state_t        state_q, state_d;
  logic [WIDTH-1:0]  cnt_q;
  logic              done_q;

  logic              cmd_valid_q;
  logic              cmd_rw_q;
  logic [WIDTH-1:0]  cmd_addr_q;
  logic [LENGHT-1:0] cmd_din_q;
  req_id_t           cmd_id_q;

  logic              tag1_valid_q, tag2_valid_q;
  req_id_t           tag1_id_q, tag2_id_q;

  logic [1:0]        grant;
  logic              arb_enable;
  logic              accept;
  req_id_t           acc_id;
  logic              acc_rw;
  logic [WIDTH-1:0]  acc_addr;
  logic [LENGHT-1:0] acc_din;

  // Clear_Req and Reset both block acceptance in the cycle they are seen.
  assign arb_enable = (state_q == ARB_RUN) && !Clear_Req && !Reset;
  assign accept     = |(grant & {Req1_Valid, Req0_Valid});
  assign acc_id     = grant[1] ? CLIENT1 : CLIENT0;
  assign acc_rw     = grant[1] ? Req1_RW   : Req0_RW;
  assign acc_addr   = grant[1] ? Req1_Addr : Req0_Addr;
  assign acc_din    = grant[1] ? Req1_Din  : Req0_Din;

  rr_arbiter2 u_rr (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       ({Req1_Valid, Req0_Valid}),
    .enable    (arb_enable),
    .handshake (accept),
    .grant     (grant)
  );

  always_comb begin
    state_d   = state_q;
    Busy      = 1'b0;
    Mem_Valid = cmd_valid_q;
    Mem_RW    = cmd_valid_q & cmd_rw_q;
    Mem_Addr  = cmd_valid_q ? cmd_addr_q : '0;
    Mem_Din   = cmd_valid_q ? cmd_din_q  : '0;
    unique case (state_q)
      ARB_RUN: begin
        if (Clear_Req) state_d = ARB_CLEAR;
      end
      ARB_CLEAR: begin
        Busy      = 1'b1;
        Mem_Valid = 1'b1;
        Mem_RW    = 1'b1;
        Mem_Addr  = cnt_q;
        Mem_Din   = '0;
        if (cnt_q == '1) state_d = ARB_RUN;
      end
      default: state_d = ARB_RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ARB_RUN;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_rw_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_din_q    <= '0;
      cmd_id_q     <= CLIENT0;
      tag1_valid_q <= 1'b0;
      tag1_id_q    <= CLIENT0;
      tag2_valid_q <= 1'b0;
      tag2_id_q    <= CLIENT0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == ARB_CLEAR) && (cnt_q == '1);
      // Counter wraps back to zero on the last sweep cycle, ready for the next sweep.
      cnt_q   <= (state_q == ARB_CLEAR) ? cnt_q + 1'b1 : '0;

      cmd_valid_q <= accept;
      if (accept) begin
        cmd_rw_q   <= acc_rw;
        cmd_addr_q <= acc_addr;
        cmd_din_q  <= acc_din;
        cmd_id_q   <= acc_id;
      end

      tag1_valid_q <= accept && !acc_rw;
      tag1_id_q    <= acc_id;
      tag2_valid_q <= tag1_valid_q;
      tag2_id_q    <= tag1_id_q;
    end
  end

  assign Req0_Ready = grant[0];
  assign Req1_Ready = grant[1];
  assign Rsp0_Valid = tag2_valid_q && (tag2_id_q == CLIENT0);
  assign Rsp1_Valid = tag2_valid_q && (tag2_id_q == CLIENT1);
  assign Rsp0_Data  = Mem_Dout;
  assign Rsp1_Data  = Mem_Dout;
  assign Clear_Done = done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a cycle-level behavioural model with a memory.
module tb_mem_arbiter;

  localparam int W     = 8;
  localparam int L     = 32;
  localparam int DEPTH = 256;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Req0_Valid, Req0_RW, Req1_Valid, Req1_RW;
  logic [W-1:0] Req0_Addr, Req1_Addr;
  logic [L-1:0] Req0_Din, Req1_Din;
  logic         Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid;
  logic [L-1:0] Rsp0_Data, Rsp1_Data;
  logic         Clear_Req, Busy, Clear_Done;
  logic [L-1:0] Mem_Din, Mem_Dout;
  logic [W-1:0] Mem_Addr;
  logic         Mem_RW, Mem_Valid;

  always #5 Clk = ~Clk;

  mem_arbiter #(.WIDTH(W), .LENGHT(L)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0_Valid(Req0_Valid), .Req0_RW(Req0_RW), .Req0_Addr(Req0_Addr), .Req0_Din(Req0_Din),
    .Req0_Ready(Req0_Ready),
    .Req1_Valid(Req1_Valid), .Req1_RW(Req1_RW), .Req1_Addr(Req1_Addr), .Req1_Din(Req1_Din),
    .Req1_Ready(Req1_Ready),
    .Rsp0_Valid(Rsp0_Valid), .Rsp0_Data(Rsp0_Data), .Rsp1_Valid(Rsp1_Valid), .Rsp1_Data(Rsp1_Data),
    .Clear_Req(Clear_Req), .Busy(Busy), .Clear_Done(Clear_Done),
    .Mem_Din(Mem_Din), .Mem_Addr(Mem_Addr), .Mem_RW(Mem_RW), .Mem_Valid(Mem_Valid),
    .Mem_Dout(Mem_Dout)
  );

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h00C0FFEE;
  endfunction

  // Memory instance stand-in: writes or loads Dout at the end of a Valid cycle.
  logic [L-1:0] env_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) env_mem[i] = init_word(i);
    Mem_Dout = '0;
    forever begin
      @(posedge Clk);
      if (Mem_Valid === 1'b1) begin
        if (Mem_RW) env_mem[Mem_Addr] = Mem_Din;
        else        Mem_Dout <= env_mem[Mem_Addr];
      end
    end
  end

  // Reference model state
  logic [L-1:0] mdl_mem [DEPTH];
  bit           m_on = 0, m_last = 1, m_done = 0;
  int           m_sweep_left = 0, m_sweep_addr = 0;
  bit           m_iv = 0, m_irw = 0, m_iid = 0;
  logic [W-1:0] m_iaddr = '0;
  logic [L-1:0] m_idin = '0;
  bit           m_rv = 0, m_rid = 0;
  logic [L-1:0] m_rdata = '0;

  initial begin
    bit           chk_on, clearing, eg0, eg1, emv, erw, n_rv, n_rid;
    logic [W-1:0] eaddr;
    logic [L-1:0] edin, n_rdata;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = init_word(i);
    forever begin
      @(negedge Clk);
      chk_on = m_on;
      if (Reset === 1'b1) m_on = 1;
      clearing = (m_sweep_left > 0);
      eg0 = 0;
      eg1 = 0;
      if (!Reset && !clearing && !Clear_Req) begin
        if (Req0_Valid && Req1_Valid) begin
          if (m_last) eg0 = 1; else eg1 = 1;
        end else begin
          eg0 = Req0_Valid;
          eg1 = Req1_Valid;
        end
      end
      if (clearing) begin
        emv = 1; erw = 1; eaddr = W'(m_sweep_addr); edin = '0;
      end else begin
        emv = m_iv; erw = m_irw; eaddr = m_iaddr; edin = m_idin;
      end

      if (chk_on) begin
        chk("Req0_Ready", Req0_Ready, eg0);
        chk("Req1_Ready", Req1_Ready, eg1);
        chk("Rsp0_Valid", Rsp0_Valid, m_rv && !m_rid);
        chk("Rsp1_Valid", Rsp1_Valid, m_rv && m_rid);
        if (m_rv && !m_rid) chk("Rsp0_Data", Rsp0_Data, m_rdata);
        if (m_rv && m_rid)  chk("Rsp1_Data", Rsp1_Data, m_rdata);
        chk("Busy", Busy, clearing);
        chk("Clear_Done", Clear_Done, m_done);
        chk("Mem_Valid", Mem_Valid, emv);
        if (emv) begin
          chk("Mem_RW", Mem_RW, erw);
          chk("Mem_Addr", Mem_Addr, eaddr);
          if (erw) chk("Mem_Din", Mem_Din, edin);
        end
      end

      // Advance to the next cycle
      n_rv    = emv && !erw;
      n_rid   = m_iid;
      n_rdata = mdl_mem[eaddr];
      if (emv && erw) mdl_mem[eaddr] = edin;
      if (Reset) begin
        m_last = 1; m_sweep_left = 0; m_sweep_addr = 0; m_done = 0; m_iv = 0; m_rv = 0;
      end else begin
        m_done = clearing && (m_sweep_left == 1);
        m_rv = n_rv; m_rid = n_rid; m_rdata = n_rdata;
        if (clearing) begin
          m_sweep_left--;
          m_sweep_addr++;
        end else if (Clear_Req) begin
          m_sweep_left = DEPTH;
          m_sweep_addr = 0;
        end
        m_iv = eg0 || eg1;
        if (eg0) begin
          m_irw = Req0_RW; m_iaddr = Req0_Addr; m_idin = Req0_Din; m_iid = 0; m_last = 0;
        end else if (eg1) begin
          m_irw = Req1_RW; m_iaddr = Req1_Addr; m_idin = Req1_Din; m_iid = 1; m_last = 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    Req0_Valid = 0; Req0_RW = 0; Req0_Addr = '0; Req0_Din = '0;
    Req1_Valid = 0; Req1_RW = 0; Req1_Addr = '0; Req1_Din = '0;
    Clear_Req  = 0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_Req0_Ready"}, Req0_Ready, 0);
    chk({tag, "_Req1_Ready"}, Req1_Ready, 0);
    chk({tag, "_Rsp0_Valid"}, Rsp0_Valid, 0);
    chk({tag, "_Rsp1_Valid"}, Rsp1_Valid, 0);
    chk({tag, "_Busy"}, Busy, 0);
    chk({tag, "_Clear_Done"}, Clear_Done, 0);
    chk({tag, "_Mem_Valid"}, Mem_Valid, 0);
    chk({tag, "_Mem_RW"}, Mem_RW, 0);
    chk({tag, "_Mem_Addr"}, Mem_Addr, 0);
    chk({tag, "_Mem_Din"}, Mem_Din, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy_n;
    bit seen;
    Reset = 1;
    idle();
    tick(); tick(); tick();
    @(negedge Clk);
    chk_all_zero("reset");
    tick();
    Reset = 0;

    // Write then read of the same address from the other client
    Req0_Valid = 1; Req0_RW = 1; Req0_Addr = 8'h10; Req0_Din = 32'hDEADBEEF;
    tick();
    idle();
    Req1_Valid = 1; Req1_RW = 0; Req1_Addr = 8'h10;
    @(negedge Clk);
    chk("s1_read_ready", Req1_Ready, 1);
    tick();
    idle();
    tick();
    @(negedge Clk);
    chk("s1_rsp1_valid", Rsp1_Valid, 1);
    chk("s1_rsp1_data", Rsp1_Data, 32'hDEADBEEF);
    chk("s1_rsp0_valid", Rsp0_Valid, 0);
    tick();

    // Both clients reading: grants alternate starting with client 0
    Req0_Valid = 1; Req0_Addr = 8'h10; Req1_Valid = 1; Req1_Addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      chk("s2_ready0", Req0_Ready, (k % 2) == 0);
      chk("s2_ready1", Req1_Ready, (k % 2) == 1);
      tick();
    end
    idle();
    tick(); tick();

    // Write 5 to 0xFF, then a sweep raised together with a read request
    Req0_Valid = 1; Req0_RW = 1; Req0_Addr = 8'hFF; Req0_Din = 32'h5;
    tick();
    Req0_RW = 0; Clear_Req = 1;
    @(negedge Clk);
    chk("s3_ready_on_clear", Req0_Ready, 0);
    tick();
    Clear_Req = 0;
    busy_n = 0;
    seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge Clk);
      if (Busy === 1'b1) busy_n++;
      if (Clear_Done === 1'b1) begin
        seen = 1;
        chk("s3_ready_at_done", Req0_Ready, 1);
      end else begin
        tick();
      end
    end
    chk("s3_busy_cycles", busy_n, 256);
    chk("s3_done_seen", seen, 1);
    tick();
    idle();
    tick();
    @(negedge Clk);
    chk("s3_rsp0_valid", Rsp0_Valid, 1);
    chk("s3_rsp0_cleared", Rsp0_Data, 0);
    tick();

    // Reset right after a read is accepted
    Req1_Valid = 1; Req1_RW = 0; Req1_Addr = 8'h33;
    @(negedge Clk);
    chk("s4_read_ready", Req1_Ready, 1);
    tick();
    idle();
    Reset = 1;
    tick();
    Reset = 0;
    @(negedge Clk);
    chk_all_zero("s4_after_reset");
    tick();

    // Reset in the middle of a sweep at counter 0x40
    Clear_Req = 1;
    tick();
    Clear_Req = 0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (Busy === 1'b1 && Mem_Addr === 8'h40) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("s5_reached_0x40", seen, 1);
    Reset = 1;
    tick();
    Reset = 0;
    Req0_Valid = 1; Req0_RW = 0; Req0_Addr = 8'h40;
    @(negedge Clk);
    chk("s5_busy_dropped", Busy, 0);
    chk("s5_no_done", Clear_Done, 0);
    chk("s5_ready_resumes", Req0_Ready, 1);
    tick();
    idle();
    tick(); tick();

    // Randomized traffic with occasional sweeps and resets
    for (int n = 0; n < 3000; n++) begin
      Reset      = ($urandom_range(0, 499) == 0);
      Clear_Req  = ($urandom_range(0, 399) == 0);
      Req0_Valid = ($urandom_range(0, 9) < 6);
      Req1_Valid = ($urandom_range(0, 9) < 6);
      Req0_RW    = $urandom_range(0, 1);
      Req1_RW    = $urandom_range(0, 1);
      Req0_Addr  = W'($urandom_range(0, 15));
      Req1_Addr  = W'($urandom_range(0, 15));
      Req0_Din   = $urandom;
      Req1_Din   = $urandom;
      tick();
    end
    Reset = 0;
    idle();
    for (int n = 0; n < 300; n++) tick();
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
